// File: rtl/mdr_load_buffer_if.sv
// Load-path handshake bundle between data memory, mdr_load_buffer and writeback.
// The master modport is the memory/writeback side; the slave modport is the buffer.
interface mdr_load_buffer_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             mdr_in_valid;
  logic             mdr_in_ready;
  logic [31:0]      mdr_in;
  logic [2:0]       mdr_funct3;
  logic [1:0]       mdr_offset;
  logic             mdr_flush;
  logic             mdr_out_valid;
  logic             mdr_out_ready;
  logic [31:0]      mdr_out;
  logic             mdr_err;
  logic [CNT_W-1:0] mdr_count;

  modport master (
    output mdr_in_valid, mdr_in, mdr_funct3, mdr_offset, mdr_flush, mdr_out_ready,
    input  mdr_in_ready, mdr_out_valid, mdr_out, mdr_err, mdr_count
  );

  modport slave (
    input  mdr_in_valid, mdr_in, mdr_funct3, mdr_offset, mdr_flush, mdr_out_ready,
    output mdr_in_ready, mdr_out_valid, mdr_out, mdr_err, mdr_count
  );
endinterface

// File: rtl/mdr_load_buffer.sv
// Multi-entry load data register: formats RISC-V loads on push and queues them for writeback.
// Optional MDR_BYPASS_EN adds a zero-latency path when the queue is empty.
module mdr_load_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                mdr_clk,
  input  logic                mdr_rst,
  mdr_load_buffer_if.slave    bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } entry_t;

  function automatic entry_t format_load(input logic [31:0] word,
                                         input logic [2:0]  f3,
                                         input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    entry_t      r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    // Anything not explicitly legal and aligned falls through as an error entry.
    r = '{err: 1'b1, data: '0};
    case (f3)
      3'b000: r = '{err: 1'b0, data: {{24{b[7]}}, b}};
      3'b100: r = '{err: 1'b0, data: {24'h0, b}};
      3'b001: if (!off[0]) r = '{err: 1'b0, data: {{16{h[15]}}, h}};
      3'b101: if (!off[0]) r = '{err: 1'b0, data: {16'h0, h}};
      3'b010: if (off == 2'b00) r = '{err: 1'b0, data: word};
      default: r = '{err: 1'b1, data: '0};
    endcase
    return r;
  endfunction

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  entry_t in_fmt;
  logic   full;
  logic   empty;
  logic   in_ready;
  logic   bypass;
  logic   push;
  logic   pop;

  always_comb begin
    in_fmt   = format_load(bus.mdr_in, bus.mdr_funct3, bus.mdr_offset);
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    in_ready = !full && !mdr_rst;
`ifdef MDR_BYPASS_EN
    bypass   = empty && bus.mdr_in_valid && bus.mdr_out_ready && !bus.mdr_flush && !mdr_rst;
`else
    bypass   = 1'b0;
`endif
    push     = bus.mdr_in_valid && in_ready && !bypass;
    pop      = !empty && bus.mdr_out_ready;
  end

  always_ff @(posedge mdr_clk or posedge mdr_rst) begin
    if (mdr_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.mdr_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: empty entries are never visible on the outputs.
  always_ff @(posedge mdr_clk) begin
    if (push && !bus.mdr_flush) mem_q[wr_ptr_q] <= in_fmt;
  end

  always_comb begin
    bus.mdr_in_ready  = in_ready;
    bus.mdr_count     = count_q;
    bus.mdr_out_valid = !empty || bypass;
    bus.mdr_out       = '0;
    bus.mdr_err       = 1'b0;
    if (!empty) begin
      bus.mdr_out = mem_q[rd_ptr_q].data;
      bus.mdr_err = mem_q[rd_ptr_q].err;
    end else if (bypass) begin
      bus.mdr_out = in_fmt.data;
      bus.mdr_err = in_fmt.err;
    end
  end
endmodule

// File: tb/tb_mdr_load_buffer.sv
// Self-checking bench for mdr_load_buffer (DEPTH=4) against a queue-based load model.
// Honours MDR_BYPASS_EN when the same define is applied to the build.
module tb_mdr_load_buffer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [32:0] exp_q[$];

  mdr_load_buffer_if #(.DEPTH(DEPTH)) bus ();

  mdr_load_buffer #(.DEPTH(DEPTH)) dut (
    .mdr_clk (clk),
    .mdr_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference formatting: {err, data} from byte/half arithmetic on the raw word.
  function automatic logic [32:0] ref_fmt(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    int unsigned o = off;
    int unsigned b = (w >> (8 * o)) % 256;
    int unsigned h = (w >> (16 * (o / 2))) % 65536;
    logic [31:0] d;
    case (f3)
      3'd0: begin d = b; if (b >= 128) d = d + 32'hFFFF_FF00; return {1'b0, d}; end
      3'd4: begin d = b; return {1'b0, d}; end
      3'd1: begin
        if (o % 2 != 0) return {1'b1, 32'h0};
        d = h; if (h >= 32768) d = d + 32'hFFFF_0000; return {1'b0, d};
      end
      3'd5: begin
        if (o % 2 != 0) return {1'b1, 32'h0};
        d = h; return {1'b0, d};
      end
      3'd2: return (o == 0) ? {1'b0, w} : {1'b1, 32'h0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Advance one clock while updating the model from the inputs held across the edge.
  task automatic cycle();
    bit acc, pop, byp;
    logic [32:0] f;
    byp = 0;
`ifdef MDR_BYPASS_EN
    byp = (exp_q.size() == 0) && bus.mdr_in_valid && bus.mdr_out_ready && !bus.mdr_flush;
`endif
    acc = bus.mdr_in_valid && (exp_q.size() < DEPTH) && !byp;
    pop = (exp_q.size() > 0) && bus.mdr_out_ready;
    f   = ref_fmt(bus.mdr_in, bus.mdr_funct3, bus.mdr_offset);
    @(posedge clk);
    if (bus.mdr_flush) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(f);
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.mdr_in_valid  = 0;
    bus.mdr_in        = '0;
    bus.mdr_funct3    = '0;
    bus.mdr_offset    = '0;
    bus.mdr_flush     = 0;
    bus.mdr_out_ready = 0;
  endtask

  task automatic push_one(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    bus.mdr_in_valid = 1; bus.mdr_in = w; bus.mdr_funct3 = f3; bus.mdr_offset = off;
    bus.mdr_out_ready = 0;
    cycle();
    bus.mdr_in_valid = 0;
  endtask

  task automatic flush_all();
    bus.mdr_flush = 1; cycle(); bus.mdr_flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    checks++; if (bus.mdr_count !== 0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.mdr_count); end
    checks++; if (bus.mdr_out_valid !== 0 || bus.mdr_out !== 0 || bus.mdr_err !== 0) begin
      errors++; $display("FAIL reset_out got v=%b d=%h e=%b exp 0/0/0", bus.mdr_out_valid, bus.mdr_out, bus.mdr_err); end
    checks++; if (bus.mdr_in_ready !== 0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.mdr_in_ready); end
    @(posedge clk); #1; rst = 0; #1;
    checks++; if (bus.mdr_in_ready !== 1) begin errors++; $display("FAIL release_ready got %b exp 1", bus.mdr_in_ready); end
  endtask

  task automatic test_format();
    logic [31:0] exp_d [6] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_ABCD, 32'h0000_ABCD, 32'h0, 32'h0};
    logic        exp_e [6] = '{0, 0, 0, 0, 1, 1};
    logic [31:0] wd    [6] = '{32'h1234_80FF, 32'h1234_80FF, 32'hABCD_0001, 32'hABCD_0001, 32'hABCD_0001, 32'h1111_2222};
    logic [2:0]  f3    [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b011};
    logic [1:0]  of    [6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      push_one(wd[i], f3[i], of[i]);
      checks++; if (bus.mdr_out !== exp_d[i] || bus.mdr_err !== exp_e[i]) begin
        errors++; $display("FAIL format_%0d got %h/%b exp %h/%b", i, bus.mdr_out, bus.mdr_err, exp_d[i], exp_e[i]); end
      checks++; if (bus.mdr_count !== 1 || bus.mdr_out_valid !== 1) begin
        errors++; $display("FAIL format_count_%0d got %0d/%b exp 1/1", i, bus.mdr_count, bus.mdr_out_valid); end
      flush_all();
    end
  endtask

  task automatic test_full();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; push_one(w[i], 3'b010, 2'd0); end
    checks++; if (bus.mdr_count !== 4 || bus.mdr_in_ready !== 0) begin
      errors++; $display("FAIL full_state got cnt=%0d rdy=%b exp 4/0", bus.mdr_count, bus.mdr_in_ready); end
    push_one(32'hCAFE_F00D, 3'b010, 2'd0);
    checks++; if (bus.mdr_count !== 4 || bus.mdr_out !== w[0]) begin
      errors++; $display("FAIL full_reject got cnt=%0d d=%h exp 4/%h", bus.mdr_count, bus.mdr_out, w[0]); end
    bus.mdr_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.mdr_out !== w[i] || bus.mdr_count !== 4 - i) begin
        errors++; $display("FAIL drain_%0d got %h cnt=%0d exp %h cnt=%0d", i, bus.mdr_out, bus.mdr_count, w[i], 4 - i); end
      cycle();
    end
    checks++; if (bus.mdr_count !== 0 || bus.mdr_out_valid !== 0 || bus.mdr_out !== 0) begin
      errors++; $display("FAIL drain_empty got cnt=%0d v=%b d=%h exp 0/0/0", bus.mdr_count, bus.mdr_out_valid, bus.mdr_out); end
    cycle();
    checks++; if (bus.mdr_count !== 0) begin errors++; $display("FAIL empty_pop got %0d exp 0", bus.mdr_count); end
    bus.mdr_out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin w = $urandom; q.push_back(w); push_one(w, 3'b010, 2'd0); end
    bus.mdr_out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      w = $urandom;
      bus.mdr_in_valid = 1; bus.mdr_in = w; bus.mdr_funct3 = 3'b010; bus.mdr_offset = 2'd0;
      checks++; if (bus.mdr_out !== q[0]) begin errors++; $display("FAIL b2b_data_%0d got %h exp %h", i, bus.mdr_out, q[0]); end
      cycle();
      void'(q.pop_front()); q.push_back(w);
      checks++; if (bus.mdr_count !== 2) begin errors++; $display("FAIL b2b_count_%0d got %0d exp 2", i, bus.mdr_count); end
    end
    bus.mdr_in_valid = 0; bus.mdr_out_ready = 0;
    flush_all();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_one($urandom, 3'b010, 2'd0);
    bus.mdr_flush = 1; bus.mdr_in_valid = 1; bus.mdr_in = 32'h5555_AAAA; bus.mdr_funct3 = 3'b010;
    cycle();
    bus.mdr_flush = 0; bus.mdr_in_valid = 0;
    checks++; if (bus.mdr_count !== 0 || bus.mdr_out_valid !== 0 || bus.mdr_out !== 0) begin
      errors++; $display("FAIL flush got cnt=%0d v=%b d=%h exp 0/0/0", bus.mdr_count, bus.mdr_out_valid, bus.mdr_out); end
    push_one(32'h0000_0077, 3'b000, 2'd0);
    checks++; if (bus.mdr_out !== 32'h77 || bus.mdr_count !== 1) begin
      errors++; $display("FAIL post_flush got %h cnt=%0d exp 00000077/1", bus.mdr_out, bus.mdr_count); end
    push_one(32'h8000_0000, 3'b010, 2'd0);
    rst = 1; #1;
    exp_q.delete();
    checks++; if (bus.mdr_out_valid !== 0 || bus.mdr_out !== 0 || bus.mdr_err !== 0 || bus.mdr_count !== 0) begin
      errors++; $display("FAIL mid_reset got v=%b d=%h e=%b cnt=%0d exp 0", bus.mdr_out_valid, bus.mdr_out, bus.mdr_err, bus.mdr_count); end
    @(posedge clk); #1; rst = 0; #1;
  endtask

  task automatic test_bypass();
    bus.mdr_in_valid = 1; bus.mdr_in = 32'hDEAD_BEEF; bus.mdr_funct3 = 3'b010; bus.mdr_offset = 2'd0;
    bus.mdr_out_ready = 1;
    #1;
`ifdef MDR_BYPASS_EN
    checks++; if (bus.mdr_out !== 32'hDEAD_BEEF || bus.mdr_out_valid !== 1 || bus.mdr_count !== 0) begin
      errors++; $display("FAIL bypass_same got %h v=%b cnt=%0d exp deadbeef/1/0", bus.mdr_out, bus.mdr_out_valid, bus.mdr_count); end
    cycle();
    bus.mdr_in_valid = 0; #1;
    checks++; if (bus.mdr_count !== 0 || bus.mdr_out_valid !== 0) begin
      errors++; $display("FAIL bypass_nowrite got cnt=%0d v=%b exp 0/0", bus.mdr_count, bus.mdr_out_valid); end
`else
    checks++; if (bus.mdr_out_valid !== 0 || bus.mdr_out !== 0) begin
      errors++; $display("FAIL no_comb_path got v=%b d=%h exp 0/0", bus.mdr_out_valid, bus.mdr_out); end
    cycle();
    bus.mdr_in_valid = 0;
    checks++; if (bus.mdr_out !== 32'hDEAD_BEEF || bus.mdr_out_valid !== 1 || bus.mdr_count !== 1) begin
      errors++; $display("FAIL latency1 got %h v=%b cnt=%0d exp deadbeef/1/1", bus.mdr_out, bus.mdr_out_valid, bus.mdr_count); end
    cycle();
`endif
    bus.mdr_out_ready = 0;
  endtask

  task automatic test_random();
    logic [32:0] e;
    for (int i = 0; i < 400; i++) begin
      bus.mdr_in_valid  = ($urandom_range(0, 3) != 0);
      bus.mdr_out_ready = ($urandom_range(0, 2) != 0);
      bus.mdr_flush     = ($urandom_range(0, 31) == 0);
      bus.mdr_in        = $urandom;
      bus.mdr_funct3    = 3'($urandom_range(0, 7));
      bus.mdr_offset    = 2'($urandom_range(0, 3));
      #1;
      e = (exp_q.size() > 0) ? exp_q[0] : 33'h0;
`ifdef MDR_BYPASS_EN
      if (exp_q.size() == 0 && bus.mdr_in_valid && bus.mdr_out_ready && !bus.mdr_flush)
        e = ref_fmt(bus.mdr_in, bus.mdr_funct3, bus.mdr_offset);
`endif
      checks++; if ({bus.mdr_err, bus.mdr_out} !== e) begin
        errors++; $display("FAIL rand_out_%0d got %b/%h exp %b/%h", i, bus.mdr_err, bus.mdr_out, e[32], e[31:0]); end
      checks++; if (bus.mdr_count !== exp_q.size() || bus.mdr_in_ready !== (exp_q.size() < DEPTH)) begin
        errors++; $display("FAIL rand_cnt_%0d got %0d rdy=%b exp %0d", i, bus.mdr_count, bus.mdr_in_ready, exp_q.size()); end
      cycle();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_format();
    test_full();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdr_load_buffer.md
# mdr_load_buffer

Parametrised memory data register for the load path: accepts raw 32-bit memory read words with a valid/ready handshake, formats them per RISC-V load type (LB/LH/LW/LBU/LHU) using the byte offset, and holds up to DEPTH formatted results in a FIFO until writeback consumes them. Sits between data memory and the register-file writeback mux. It replaces the single-entry memory data register with multi-entry buffering, sub-word extraction, misalignment flagging and flush.

## Interface
- DEPTH, 2, number of buffered results; power of two, 2..16
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

- mdr_clk  in  1  clock, all state on rising edge
- mdr_rst  in  1  reset, asynchronous, active-high
- mdr_in_valid  in  1  memory word present
- mdr_in_ready  out  1  buffer can accept
- mdr_in  in  32  raw memory read word
- mdr_funct3  in  3  load type, sampled with mdr_in
- mdr_offset  in  2  address[1:0], sampled with mdr_in
- mdr_flush  in  1  synchronous discard of all entries
- mdr_out_valid  out  1  head entry valid
- mdr_out_ready  in  1  writeback consumes head
- mdr_out  out  32  formatted head data
- mdr_err  out  1  head entry is misaligned or has an illegal funct3
- mdr_count  out  CNT_W  current occupancy

One clock; reset is asynchronous and active-high.

## Operation
- Push when mdr_in_valid & mdr_in_ready; pop when mdr_out_valid & mdr_out_ready.
- mdr_in_ready = !full & !mdr_rst; no push-through when full, even if a pop happens in the same cycle.
- Formatting is done on push; each entry stores 32-bit data + err bit.
  - 000 LB: byte at offset, sign-extended. 100 LBU: same byte, zero-extended.
  - 001 LH: half at offset[1]*16, sign-extended. 101 LHU: same half, zero-extended. offset[0]=1 -> misaligned.
  - 010 LW: whole word; offset!=0 -> misaligned.
  - Any other funct3 -> illegal.
  - Misaligned or illegal: stored data = 32'h0, err=1.
- FIFO: read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; mdr_count is tracked separately.
- Simultaneous push and pop while non-empty and non-full: count unchanged and both pointers advance.
- mdr_flush has priority over push and pop in the same cycle: pointers and count go to 0, and the input word in that cycle is dropped.
- mdr_out and mdr_err show the head entry when non-empty and 0 when empty; mdr_out_valid = (count != 0).

## Timing
- Reset (asynchronous, immediate): count=0, pointers=0, mdr_out_valid=0, mdr_out=0, mdr_err=0, mdr_in_ready=0 while mdr_rst is high. mdr_in_ready goes to 1 combinationally once mdr_rst is released.
- Default latency: a word pushed in cycle N appears on mdr_out in cycle N+1.
- Output holds stable while mdr_out_valid & !mdr_out_ready.
- Full (count=DEPTH): mdr_in_ready=0; the pop frees a slot, and ready rises the next cycle.
- Empty: a pop request is ignored; count never underflows.
- Reset asserted mid-transfer: all entries are lost and there is no partial state.

## Configuration
- MDR_BYPASS_EN defined: when the FIFO is empty, mdr_in_valid=1 and mdr_out_ready=1 (no flush), the formatted input drives mdr_out and mdr_err combinationally.
  - mdr_out_valid=1 in that same cycle, latency 0, and nothing is written.
  - When the FIFO is empty and mdr_out_ready=0, the word is pushed normally.
- MDR_BYPASS_EN undefined: there is no combinational input-to-output path; minimum latency is 1 cycle.

## Test plan
- Reset then LB of 32'h1234_80FF at offset 1 -> next cycle mdr_out=32'hFFFF_FF80, mdr_err=0, count=1; the same word as LBU at offset 0 -> 32'h0000_00FF.
- LH at offset 2 of 32'hABCD_0001 -> 32'hFFFF_ABCD; LHU -> 32'h0000_ABCD; LH at offset 1 -> mdr_out=0, mdr_err=1; funct3=011 -> mdr_err=1.
- DEPTH=4: push 4 words with mdr_out_ready=0 -> count=4, mdr_in_ready=0; a fifth valid word is not accepted; pop all 4 -> data comes out in order, count 0, then mdr_out_valid=0 and mdr_out=0.
- Simultaneous push and pop at count=2, then repeat past pointer wrap -> count stays 2 and order is preserved over 10 cycles.
- Count=3, assert mdr_flush together with mdr_in_valid -> next cycle count=0 and the input is dropped; assert mdr_rst mid-stream -> outputs go to 0 immediately.
- MDR_BYPASS_EN defined, FIFO empty, LW of 32'hDEAD_BEEF with mdr_out_ready=1 -> same-cycle mdr_out=32'hDEAD_BEEF, mdr_out_valid=1, count stays 0. Undefined -> value appears the next cycle.
